alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for one shared 64-bit ALU.
// Each request is registered, executed, then presented until the owner takes it.

module alu #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned OP_W   = 5
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [OP_W-1:0]   op,
  output logic [DATA_W-1:0] y
);
  localparam int unsigned SH_W = $clog2(DATA_W);

  logic [SH_W-1:0] sh;
  logic [SH_W:0]   inv_sh;

  assign sh     = b[SH_W-1:0];
  // A shift by the full width yields zero, so a zero rotate needs no special case.
  assign inv_sh = (SH_W+1)'(DATA_W) - {1'b0, sh};

  always_comb begin
    y = '0;
    case (op)
      OP_W'(0):  y = a + b;
      OP_W'(1):  y = a - b;
      OP_W'(2):  y = a & b;
      OP_W'(3):  y = a | b;
      OP_W'(4):  y = a ^ b;
      OP_W'(5):  y = ~(a | b);
      OP_W'(6):  y = a << sh;
      OP_W'(7):  y = a >> sh;
      OP_W'(8):  y = $signed(a) >>> sh;
      OP_W'(9):  y = DATA_W'($signed(a) < $signed(b));
      OP_W'(10): y = DATA_W'(a < b);
      OP_W'(11): y = ($signed(a) < $signed(b)) ? a : b;
      OP_W'(12): y = ($signed(a) > $signed(b)) ? a : b;
      OP_W'(13): y = (a < b) ? a : b;
      OP_W'(14): y = (a > b) ? a : b;
      OP_W'(15): y = a * b;
      OP_W'(16): y = DATA_W'(a == b);
      OP_W'(17): y = DATA_W'(a != b);
      OP_W'(18): y = a;
      OP_W'(19): y = b;
      OP_W'(20): y = ~a;
      OP_W'(21): y = DATA_W'(0) - a;
      OP_W'(22): y = a + DATA_W'(1);
      OP_W'(23): y = a - DATA_W'(1);
      OP_W'(24): y = a & ~b;
      OP_W'(25): y = a | ~b;
      OP_W'(26): y = ~(a ^ b);
      OP_W'(27): y = ~(a & b);
      OP_W'(28): y = (a << sh) | (a >> inv_sh);
      OP_W'(29): y = (a >> sh) | (a << inv_sh);
      OP_W'(30): y = a[DATA_W-1] ? DATA_W'(0) - a : a;
      OP_W'(31): y = b - a;
      default:   y = '0;
    endcase
  end
endmodule

module alu_arbiter #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned OP_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_0,
  input  logic              req_valid_1,
  output logic              req_ready_0,
  output logic              req_ready_1,
  input  logic [DATA_W-1:0] req_a_0,
  input  logic [DATA_W-1:0] req_b_0,
  input  logic [DATA_W-1:0] req_a_1,
  input  logic [DATA_W-1:0] req_b_1,
  input  logic [OP_W-1:0]   req_op_0,
  input  logic [OP_W-1:0]   req_op_1,
  output logic              rsp_valid_0,
  output logic              rsp_valid_1,
  input  logic              rsp_ready_0,
  input  logic              rsp_ready_1,
  output logic [DATA_W-1:0] rsp_result,
  output logic              busy,
  output logic [31:0]       ops_done
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e            state_q, state_d;
  logic              ptr_q, ptr_d;
  logic              owner_q, owner_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [31:0]       ops_done_q, ops_done_d;
  logic [DATA_W-1:0] alu_y;
  logic              win;

  alu #(.DATA_W(DATA_W), .OP_W(OP_W)) u_alu (
    .a  (a_q),
    .b  (b_q),
    .op (op_q),
    .y  (alu_y)
  );

  // Next state, grant and capture; ready is combinational so the grant lands this cycle.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    result_d    = result_q;
    ops_done_d  = ops_done_q;
    req_ready_0 = 1'b0;
    req_ready_1 = 1'b0;
    win         = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rst && (req_valid_0 || req_valid_1)) begin
          win         = (req_valid_0 && req_valid_1) ? ptr_q : req_valid_1;
          req_ready_0 = ~win;
          req_ready_1 = win;
          owner_d     = win;
          ptr_d       = ~win;
          a_d         = win ? req_a_1 : req_a_0;
          b_d         = win ? req_b_1 : req_b_0;
          op_d        = win ? req_op_1 : req_op_0;
          state_d     = EXEC;
        end
      end
      EXEC: begin
        result_d = alu_y;
        state_d  = RESP;
      end
      RESP: begin
        if (owner_q ? rsp_ready_1 : rsp_ready_0) begin
          ops_done_d = ops_done_q + 32'd1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= 1'b0;
      owner_q    <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      result_q   <= '0;
      ops_done_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      result_q   <= result_d;
      ops_done_q <= ops_done_d;
    end
  end

  // Status outputs are forced quiet while reset is held, even before the state clears.
  assign busy        = !rst && (state_q != IDLE);
  assign rsp_valid_0 = !rst && (state_q == RESP) && !owner_q;
  assign rsp_valid_1 = !rst && (state_q == RESP) && owner_q;
  assign rsp_result  = (!rst && (state_q == RESP)) ? result_q : '0;
  assign ops_done    = ops_done_q;
endmodule
